// File: rtl/mult_chain_pkg.sv
// Shared definitions for the iterative product engine: FSM encoding and latency helper.
package mult_chain_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Edges from capture (counted as edge 1) until oDone is visible.
    function automatic int mult_chain_lat(input int size, input int num_ops);
        return (num_ops - 1) * size + 1;
    endfunction

endpackage

// File: rtl/mult_chain_engine_step.sv
// One shift-add step: conditionally adds the accumulator, shifted by the bit position, to the partial.
module mult_shift_add_step #(
    parameter int W   = 128,
    parameter int SHW = 5
) (
    input  logic [W-1:0]   acc,
    input  logic [W-1:0]   partial,
    input  logic           bit_val,
    input  logic [SHW-1:0] shamt,
    output logic [W-1:0]   next_partial
);

    always_comb begin
        next_partial = partial;
        if (bit_val)
            next_partial = partial + (acc << shamt);
    end

endmodule

// File: rtl/mult_chain_engine.sv
// Iterative N-operand unsigned product engine, one multiplier bit per clock.
// Optional macro MULT_CHAIN_ZERO_SKIP_EN: finish immediately with 0 when any captured operand is zero.
module mult_chain_engine
    import mult_chain_pkg::*;
#(
    parameter int SIZE         = 32,
    parameter int NUM_OPS      = 4,
    parameter int COUNTER_SIZE = 5,
    parameter int IDX_SIZE     = 2
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [NUM_OPS*SIZE-1:0]   iData,
    input  logic                      iValid_Data,
    input  logic                      iAcknoledged,
    output logic                      oDone,
    output logic                      oIdle,
    output logic [NUM_OPS*SIZE-1:0]   oResult
);

    localparam int W = NUM_OPS * SIZE;

    state_t                  state, state_nxt;
    logic [W-1:0]            ops;
    logic [W-1:0]            acc;
    logic [W-1:0]            partial;
    logic [W-1:0]            partial_nxt;
    logic [W-1:0]            result;
    logic [IDX_SIZE-1:0]     idx;
    logic [COUNTER_SIZE-1:0] bit_cnt;
    logic [SIZE-1:0]         cur_op;
    logic                    cur_bit;
    logic                    last_bit;
    logic                    last_op;
    logic                    start_zero;
    logic                    capture;

    assign capture  = (state == S_IDLE) && iValid_Data;
    assign cur_op   = ops[idx*SIZE +: SIZE];
    assign cur_bit  = cur_op[bit_cnt];
    assign last_bit = (bit_cnt == COUNTER_SIZE'(SIZE - 1));
    assign last_op  = (idx == IDX_SIZE'(NUM_OPS - 1));

`ifdef MULT_CHAIN_ZERO_SKIP_EN
    always_comb begin
        start_zero = 1'b0;
        for (int k = 0; k < NUM_OPS; k++)
            if (iData[k*SIZE +: SIZE] == '0)
                start_zero = 1'b1;
    end
`else
    assign start_zero = 1'b0;
`endif

    mult_shift_add_step #(
        .W   (W),
        .SHW (COUNTER_SIZE)
    ) u_step (
        .acc          (acc),
        .partial      (partial),
        .bit_val      (cur_bit),
        .shamt        (bit_cnt),
        .next_partial (partial_nxt)
    );

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (iValid_Data) state_nxt = start_zero ? S_DONE : S_MULT;
            S_MULT: if (last_bit && last_op) state_nxt = S_DONE;
            S_DONE: if (iAcknoledged) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand snapshot: later iData changes cannot disturb a running product.
    always_ff @(posedge Clock) begin
        if (capture)
            ops <= iData;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            acc     <= '0;
            partial <= '0;
            result  <= '0;
            idx     <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iValid_Data) begin
                        acc     <= W'(iData[SIZE-1:0]);
                        partial <= '0;
                        idx     <= IDX_SIZE'(1);
                        bit_cnt <= '0;
                        if (start_zero)
                            result <= '0;
                    end
                end
                S_MULT: begin
                    if (last_bit) begin
                        // Product of the first idx+1 operands fits in W bits, so no truncation.
                        acc     <= partial_nxt;
                        partial <= '0;
                        bit_cnt <= '0;
                        if (last_op) begin
                            result <= partial_nxt;
                            idx    <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        partial <= partial_nxt;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oDone   = (state == S_DONE);
    assign oIdle   = (state == S_IDLE);
    assign oResult = result;

endmodule

// File: tb/tb_mult_chain_engine.sv
// Randomized self-checking bench for mult_chain_engine against a plain-arithmetic product model.
module tb_mult_chain_engine;
    import mult_chain_pkg::*;

    logic         Clock = 1'b0;
    logic         Reset;
    logic [127:0] iData;
    logic         iValid_Data;
    logic         iAcknoledged;
    logic         oDone;
    logic         oIdle;
    logic [127:0] oResult;

    logic [15:0]  data_s;
    logic         vld_s;
    logic         ack_s;
    logic         done_s;
    logic         idle_s;
    logic [15:0]  res_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    mult_chain_engine #(.SIZE(32), .NUM_OPS(4), .COUNTER_SIZE(5), .IDX_SIZE(2)) dut (
        .Clock(Clock), .Reset(Reset), .iData(iData), .iValid_Data(iValid_Data),
        .iAcknoledged(iAcknoledged), .oDone(oDone), .oIdle(oIdle), .oResult(oResult)
    );

    mult_chain_engine #(.SIZE(8), .NUM_OPS(2), .COUNTER_SIZE(3), .IDX_SIZE(1)) dut_s (
        .Clock(Clock), .Reset(Reset), .iData(data_s), .iValid_Data(vld_s),
        .iAcknoledged(ack_s), .oDone(done_s), .oIdle(idle_s), .oResult(res_s)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_prod(input logic [31:0] a, b, c, d);
        logic [127:0] p;
        p = 128'(a);
        p = p * 128'(b);
        p = p * 128'(c);
        p = p * 128'(d);
        return p;
    endfunction

    function automatic int exp_lat(input int size, input int nops, input bit any_zero);
`ifdef MULT_CHAIN_ZERO_SKIP_EN
        if (any_zero) return 1;
`endif
        return mult_chain_lat(size, nops);
    endfunction

    // Capture is edge 1; outputs are sampled on the falling edge after each rising edge.
    task automatic run_op(input logic [31:0] a, b, c, d, input int ack_at,
                          input bit both_at_end, input string tag);
        logic [127:0] exp;
        int lat, n, done_at;
        exp = model_prod(a, b, c, d);
        lat = exp_lat(32, 4, (a == 0) || (b == 0) || (c == 0) || (d == 0));
        @(negedge Clock);
        iData = {d, c, b, a};
        iValid_Data = 1'b1;
        n = 0;
        done_at = -1;
        while (done_at < 0 && n < lat + 8) begin
            @(negedge Clock);
            n++;
            if (n == 1) begin
                iValid_Data = 1'b0;
                iData = {$urandom, $urandom, $urandom, $urandom};
                check({tag, "_idle_fall"}, 128'(oIdle), 128'(0));
            end
            iAcknoledged = (n == ack_at);
            if (oDone) done_at = n;
        end
        iAcknoledged = 1'b0;
        check({tag, "_latency"}, 128'(done_at), 128'(lat));
        check({tag, "_result"}, oResult, exp);
        repeat (3) @(negedge Clock);
        check({tag, "_done_held"}, 128'({oDone, oIdle}), 128'(2'b10));
        if (both_at_end) iValid_Data = 1'b1;
        iAcknoledged = 1'b1;
        @(negedge Clock);
        iAcknoledged = 1'b0;
        iValid_Data = 1'b0;
        check({tag, "_ack"}, 128'({oDone, oIdle}), 128'(2'b01));
        check({tag, "_retain"}, oResult, exp);
        if (both_at_end) begin
            @(negedge Clock);
            check({tag, "_no_restart"}, 128'({oDone, oIdle}), 128'(2'b01));
        end
    endtask

    task automatic run_small(input logic [7:0] a, b, input string tag);
        int lat, n, done_at;
        lat = exp_lat(8, 2, (a == 0) || (b == 0));
        @(negedge Clock);
        data_s = {b, a};
        vld_s = 1'b1;
        n = 0;
        done_at = -1;
        while (done_at < 0 && n < lat + 8) begin
            @(negedge Clock);
            n++;
            if (n == 1) begin
                vld_s = 1'b0;
                data_s = 16'($urandom);
            end
            if (done_s) done_at = n;
        end
        check({tag, "_latency"}, 128'(done_at), 128'(lat));
        check({tag, "_result"}, 128'(res_s), 128'(a) * 128'(b));
        ack_s = 1'b1;
        @(negedge Clock);
        ack_s = 1'b0;
        check({tag, "_ack"}, 128'({done_s, idle_s}), 128'(2'b01));
    endtask

    initial begin
        logic [31:0] r [4];
        Reset = 1'b1;
        iData = '0;
        iValid_Data = 1'b0;
        iAcknoledged = 1'b0;
        data_s = '0;
        vld_s = 1'b0;
        ack_s = 1'b0;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        check("rst_idle", 128'(oIdle), 128'(1));
        check("rst_done", 128'(oDone), 128'(0));
        check("rst_result", oResult, 128'(0));
        check("rst_small", 128'({done_s, idle_s, res_s}), 128'({2'b01, 16'd0}));

        run_op(32'd3, 32'd5, 32'd7, 32'd11, -1, 1'b0, "basic");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, "allones");
        run_op(32'd9, 32'd0, 32'd4, 32'd2, -1, 1'b0, "zero_op");
        run_op(32'd13, 32'd17, 32'd19, 32'd23, -1, 1'b1, "vld_ack");
        run_op(32'd100, 32'd200, 32'd300, 32'd400, 10, 1'b0, "ack_mult");

        // Abort an operation part way through the multiply phase.
        @(negedge Clock);
        iData = {$urandom, $urandom, $urandom, $urandom | 32'd1};
        iValid_Data = 1'b1;
        for (int n = 1; n < 40; n++) begin
            @(negedge Clock);
            iValid_Data = 1'b0;
        end
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        check("midrst_out", 128'({oDone, oIdle}), 128'(2'b01));
        check("midrst_result", oResult, 128'(0));
        run_op(32'd2, 32'd3, 32'd4, 32'd5, -1, 1'b0, "after_rst");

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++)
                r[k] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op(r[0], r[1], r[2], r[3], -1, 1'b0, $sformatf("rand%0d", i));
        end

        run_small(8'd255, 8'd255, "small_max");
        for (int i = 0; i < 3; i++)
            run_small(8'($urandom), 8'($urandom), $sformatf("small_rand%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
